multi_fan_pwm: RTL and testbench
================================

MULTI_FAN_PWM -- requirements
Module: multi_fan_pwm

Interface
REQ-001 The block SHALL have parameter NCH, default 4: number of fan channels (1..16).
REQ-002 The block SHALL have parameter WIDTH, default 8: duty and counter width in bits, so one PWM period is 2^WIDTH clk cycles.
REQ-003 The block SHALL have parameter RAMP_STEP, default 16: maximum duty change per channel per PWM period (1..2^WIDTH-1).
REQ-004 clk  in  1  single system clock; all state SHALL be rising-edge clocked.
REQ-005 arst  in  1  asynchronous, active-low reset.
REQ-006 speed  in  NCH*WIDTH  target duty per channel; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 speed_valid  in  NCH  per-channel write strobe for speed.
REQ-008 en  in  NCH  per-channel fan enable.
REQ-009 pwm_data  out  NCH  registered PWM drive per channel.
REQ-010 ramp_busy  out  NCH  high while a channel's current duty differs from its target.
REQ-011 period_tick  out  1  one-cycle pulse in the last cycle of each PWM period.

Function
REQ-012 A shared free-running counter cnt SHALL count 0..2^WIDTH-1 and wrap to 0.
REQ-013 period_tick SHALL be high exactly in cycles where cnt == 2^WIDTH-1.
REQ-014 target[i] SHALL load speed[i] on any cycle where speed_valid[i] is high; otherwise it holds.
REQ-015 duty[i] SHALL change only in period_tick cycles, so each period uses one constant duty (glitch-free).
REQ-016 In a period_tick cycle, duty[i] SHALL be compared with the pre-update target[i]; a target written in the same cycle takes effect at the next period_tick.
REQ-017 Ramp up: if target > duty, duty SHALL become min(duty+RAMP_STEP, target), computed at WIDTH+1 bits with no wrap-around.
REQ-018 Ramp down: if target < duty, duty SHALL become max(duty-RAMP_STEP, target), with no underflow.
REQ-019 If en[i] is low, duty[i] SHALL be forced to 0 on every clock, so re-enabling always ramps up from 0.
REQ-020 pwm_data[i] SHALL be registered as en[i] AND (cnt < duty[i]), giving one cycle of latency from cnt.
REQ-021 duty 0 SHALL give a constant low output; duty D SHALL give exactly D high cycles per period.
REQ-022 ramp_busy[i] SHALL be the registered value of (en[i] AND duty[i] != target[i]).
REQ-023 Channels SHALL be fully independent; simultaneous strobes on several channels SHALL all be honoured in the same cycle.

Reset
REQ-024 While arst is low, cnt, all target, all duty, pwm_data, ramp_busy and period_tick SHALL be 0, independent of clk.
REQ-025 A reset asserted mid-ramp or mid-period SHALL abort immediately; after release, cnt restarts at 0 and all channels ramp from 0.

Structure
REQ-026 A shared package chs_pkg SHALL hold the default WIDTH and RAMP_STEP constants and the duty-type definition, for reuse by the cooling/heating system blocks.
REQ-027 The per-channel target/duty/ramp/compare logic SHALL be a sub-module fan_channel, instantiated NCH times by a generate loop; cnt and period_tick are shared in the top.

Verification (NCH=2, WIDTH=8, RAMP_STEP=16)
REQ-028 Reset, en=11, ch0 speed=64 strobed: ch0 duty SHALL go 16/32/48/64 on successive period_ticks; then pwm_data[0] is high 64 of 256 cycles, and ramp_busy[0] falls after the 4th tick.
REQ-029 ch1 target=70 from 0: duty SHALL go 16/32/48/64/70 with no overshoot; a target of 0 from 70 SHALL go 54/38/22/6/0.
REQ-030 speed_valid[0] with speed=200 in a period_tick cycle: that tick SHALL use the old target, and the ramp toward 200 SHALL begin at the following tick.
REQ-031 en[0] dropped mid-period at duty=64: pwm_data[0] SHALL go low within 1 cycle and duty SHALL become 0; re-enable SHALL restart the ramp at 16 while ch1 is unaffected.
REQ-032 arst asserted mid-ramp: all outputs SHALL be 0 immediately without a clk edge; after release, the first period_tick SHALL occur 256 cycles later.
REQ-033 speed=255 held for 16+ periods: duty SHALL saturate at 255 and pwm_data SHALL be high 255 of 256 cycles.

Source files
------------

// File: rtl/chs_pkg.sv
// Shared constants and types for the cooling/heating system blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package chs_pkg;

  // Default PWM resolution: one period is 2^CHS_WIDTH clock cycles.
  localparam int CHS_WIDTH     = 8;
  // Default largest duty change allowed per channel per PWM period.
  localparam int CHS_RAMP_STEP = 16;

  // Duty / target value at the default resolution.
  typedef logic [CHS_WIDTH-1:0] duty_t;

endpackage

// File: rtl/fan_channel.sv
// One fan channel: target register, period-synchronous duty ramp, PWM compare.
// Latency: pwm_data and ramp_busy are registered, 1 cycle after cnt/duty.
// Backpressure: none; speed strobes are always accepted on the cycle they occur.
module fan_channel #(
  parameter int WIDTH     = 8,
  parameter int RAMP_STEP = 16
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [WIDTH-1:0] cnt,
  input  logic             period_tick,
  input  logic [WIDTH-1:0] speed,
  input  logic             speed_valid,
  input  logic             en,
  output logic             pwm_data,
  output logic             ramp_busy
);

  // Step held one bit wider than duty so the ramp arithmetic never wraps.
  localparam logic [WIDTH:0] STEP = (WIDTH+1)'(RAMP_STEP);

  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] duty;
  logic [WIDTH-1:0] duty_nxt;
  logic [WIDTH:0]   up_sum;
  logic [WIDTH:0]   dn_lim;

  assign up_sum = {1'b0, duty} + STEP;
  assign dn_lim = {1'b0, target} + STEP;

  // Next duty: forced to 0 when disabled, otherwise one clamped step toward target at period end.
  always_comb begin
    duty_nxt = duty;
    if (!en) begin
      duty_nxt = '0;
    end else if (period_tick) begin
      if (target > duty) begin
        duty_nxt = (up_sum > {1'b0, target}) ? target : up_sum[WIDTH-1:0];
      end else if (target < duty) begin
        // duty >= target+STEP guarantees duty-STEP cannot underflow.
        duty_nxt = ({1'b0, duty} < dn_lim) ? target : (duty - STEP[WIDTH-1:0]);
      end
    end
  end

  // Target capture, duty update and registered PWM/busy outputs.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      target    <= '0;
      duty      <= '0;
      pwm_data  <= 1'b0;
      ramp_busy <= 1'b0;
    end else begin
      if (speed_valid) begin
        target <= speed;
      end
      duty      <= duty_nxt;
      pwm_data  <= en && (cnt < duty);
      ramp_busy <= en && (duty != target);
    end
  end

endmodule

// File: rtl/multi_fan_pwm.sv
// Multi-channel fan PWM with shared period counter and per-channel duty ramping.
// Latency: pwm_data/ramp_busy registered (1 cycle); duty moves only at period_tick.
// Backpressure: none; all per-channel strobes are honoured in the cycle they arrive.
module multi_fan_pwm
  import chs_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int WIDTH     = CHS_WIDTH,
  parameter int RAMP_STEP = CHS_RAMP_STEP
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic [NCH*WIDTH-1:0] speed,
  input  logic [NCH-1:0]       speed_valid,
  input  logic [NCH-1:0]       en,
  output logic [NCH-1:0]       pwm_data,
  output logic [NCH-1:0]       ramp_busy,
  output logic                 period_tick
);

  logic [WIDTH-1:0] cnt;

  // Free-running period counter shared by every channel; wraps naturally at 2^WIDTH.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Last cycle of the period; decoded from cnt so it is 0 whenever cnt is held in reset.
  assign period_tick = &cnt;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    fan_channel #(
      .WIDTH     (WIDTH),
      .RAMP_STEP (RAMP_STEP)
    ) u_ch (
      .clk         (clk),
      .arst        (arst),
      .cnt         (cnt),
      .period_tick (period_tick),
      .speed       (speed[i*WIDTH +: WIDTH]),
      .speed_valid (speed_valid[i]),
      .en          (en[i]),
      .pwm_data    (pwm_data[i]),
      .ramp_busy   (ramp_busy[i])
    );
  end

endmodule

// File: tb/tb_multi_fan_pwm.sv
// Directed bench for multi_fan_pwm (NCH=2, WIDTH=8, RAMP_STEP=16) with a duty scoreboard.
// Latency: expected duties are checked just after each period_tick edge.
// Backpressure: n/a.
module tb_multi_fan_pwm;
  import chs_pkg::*;

  localparam int NCH = 2;
  localparam int W   = 8;

  logic           clk = 1'b0;
  logic           arst = 1'b0;
  logic [NCH*W-1:0] speed = '0;
  logic [NCH-1:0] speed_valid = '0;
  logic [NCH-1:0] en = '0;
  logic [NCH-1:0] pwm_data;
  logic [NCH-1:0] ramp_busy;
  logic           period_tick;

  always #5 clk = ~clk;

  multi_fan_pwm #(.NCH(NCH), .WIDTH(W), .RAMP_STEP(16)) dut (
    .clk         (clk),
    .arst        (arst),
    .speed       (speed),
    .speed_valid (speed_valid),
    .en          (en),
    .pwm_data    (pwm_data),
    .ramp_busy   (ramp_busy),
    .period_tick (period_tick)
  );

  // Internal duty/target observed for checking only.
  duty_t duty0, duty1, tgt0;
  assign duty0 = dut.g_ch[0].u_ch.duty;
  assign duty1 = dut.g_ch[1].u_ch.duty;
  assign tgt0  = dut.g_ch[0].u_ch.target;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    int ch;
    int val;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int ch, input int val);
    exp_t e;
    e.ch  = ch;
    e.val = val;
    sb.push_back(e);
  endtask

  // Advance to the next falling edge on which period_tick is high (bounded).
  task automatic wait_tick();
    int n;
    n = 0;
    @(negedge clk);
    while (!period_tick && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!period_tick) check("tick_timeout", 0, 1);
  endtask

  // Pass the period_tick edge, then pop nent expectations and compare.
  task automatic sb_tick(input int nent, input string tag);
    exp_t e;
    wait_tick();
    @(posedge clk);
    #1;
    repeat (nent) begin
      if (sb.size() == 0) begin
        check({tag, "_sb_underflow"}, 0, 1);
      end else begin
        e = sb.pop_front();
        check($sformatf("%s_ch%0d_duty", tag, e.ch), (e.ch == 0) ? int'(duty0) : int'(duty1), e.val);
      end
    end
  endtask

  task automatic strobe(input int ch, input int val);
    @(negedge clk);
    speed[ch*W +: W] = W'(val);
    speed_valid[ch]  = 1'b1;
    @(negedge clk);
    speed_valid = '0;
  endtask

  task automatic count_high(input int ch, output int n);
    n = 0;
    repeat (256) begin
      @(negedge clk);
      n += int'(pwm_data[ch]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // Reset state, no clock edge needed.
    #1;
    check("rst_period_tick", int'(period_tick), 0);
    check("rst_pwm_data", int'(pwm_data), 0);
    check("rst_ramp_busy", int'(ramp_busy), 0);
    check("rst_duty0", int'(duty0), 0);
    check("rst_tgt0", int'(tgt0), 0);
    #20;
    @(negedge clk);
    arst = 1'b1;
    en   = 2'b11;

    // ch0 ramps 0 -> 64 in steps of 16.
    strobe(0, 64);
    for (int k = 1; k <= 4; k++) push(0, 16*k);
    repeat (3) sb_tick(1, "up64");
    check("busy0_during_ramp", int'(ramp_busy[0]), 1);
    sb_tick(1, "up64");
    @(posedge clk);
    #1;
    check("busy0_after_ramp", int'(ramp_busy[0]), 0);
    count_high(0, n);
    check("pwm0_high_64", n, 64);

    // ch1 ramps 0 -> 70 without overshoot, then back down to 0.
    strobe(1, 70);
    push(1, 16); push(1, 32); push(1, 48); push(1, 64); push(1, 70);
    repeat (5) sb_tick(1, "ch1_up70");
    strobe(1, 0);
    push(1, 54); push(1, 38); push(1, 22); push(1, 6); push(1, 0);
    repeat (5) sb_tick(1, "ch1_dn0");

    // Target written in the tick cycle: that tick still uses the old target (64).
    wait_tick();
    speed[7:0]     = 8'd200;
    speed_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    speed_valid = '0;
    check("same_tick_old_target_duty0", int'(duty0), 64);
    check("same_tick_tgt0", int'(tgt0), 200);
    push(0, 80); push(0, 96);
    repeat (2) sb_tick(1, "to200");

    // Simultaneous strobes: ch0 96 -> 64, ch1 0 -> 48.
    @(negedge clk);
    speed       = {8'd48, 8'd64};
    speed_valid = 2'b11;
    @(negedge clk);
    speed_valid = '0;
    push(0, 80); push(1, 16);
    push(0, 64); push(1, 32);
    push(0, 64); push(1, 48);
    repeat (3) sb_tick(2, "dual");

    // Disable ch0 mid-period, then re-enable; ch1 keeps running.
    repeat (20) @(negedge clk);
    check("pwm0_before_disable", int'(pwm_data[0]), 1);
    en[0] = 1'b0;
    @(posedge clk);
    #1;
    check("pwm0_after_disable", int'(pwm_data[0]), 0);
    check("duty0_after_disable", int'(duty0), 0);
    check("busy0_after_disable", int'(ramp_busy[0]), 0);
    check("duty1_unaffected", int'(duty1), 48);
    check("pwm1_unaffected", int'(pwm_data[1]), 1);
    @(negedge clk);
    en[0] = 1'b1;
    push(0, 16); push(1, 48);
    sb_tick(2, "reenable");

    // Asynchronous reset mid-ramp, applied between clock edges.
    repeat (30) @(negedge clk);
    check("pwm1_before_rst", int'(pwm_data[1]), 1);
    #2;
    arst = 1'b0;
    #1;
    check("arst_pwm_data", int'(pwm_data), 0);
    check("arst_ramp_busy", int'(ramp_busy), 0);
    check("arst_period_tick", int'(period_tick), 0);
    check("arst_duty0", int'(duty0), 0);
    check("arst_duty1", int'(duty1), 0);
    check("arst_tgt0", int'(tgt0), 0);
    repeat (3) @(negedge clk);
    arst = 1'b1;
    // cnt=0 in the release cycle; tick is the 256th cycle, i.e. 255 edges later.
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_tick && n < 400);
    check("rst_first_tick_edges", n, 255);
    @(posedge clk);
    #1;
    check("post_rst_duty0", int'(duty0), 0);

    // Saturation at 255 after 16 periods.
    strobe(0, 255);
    for (int k = 1; k <= 15; k++) push(0, 16*k);
    push(0, 255);
    repeat (16) sb_tick(1, "sat");
    count_high(0, n);
    check("pwm0_high_255", n, 255);
    push(0, 255);
    sb_tick(1, "sat_hold");
    check("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
